// File: rtl/raster_cmd_sched.sv
// raster_cmd_sched: CPU-to-rasterizer command FIFO with a one-outstanding issue FSM.
//
// Ports:
//   clk, rst_sync (sync, active-high)
//   cmd_push, cmd_op, cmd_colour, cmd_x0/y0/x1/y1   CPU command enqueue
//   cmd_full, cmd_overflow (sticky), sched_idle     queue status
//   gpu_command, gpu_colour, gpu_x0/y0/x1/y1        command presented to rasterizer
//   gpu_execute_request, gpu_ready, gpu_done        issue handshake
//
// Optional build macro RASTER_SCHED_COALESCE_FILL_EN: a FILL push discards queued
// work, keeping only the presented head (if any) and the FILL.
module raster_cmd_sched #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_sync,
    input  logic       cmd_push,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_colour,
    input  logic [7:0] cmd_x0,
    input  logic [7:0] cmd_y0,
    input  logic [7:0] cmd_x1,
    input  logic [7:0] cmd_y1,
    output logic       cmd_full,
    output logic       cmd_overflow,
    output logic       sched_idle,
    output logic [2:0] gpu_command,
    output logic [2:0] gpu_colour,
    output logic [7:0] gpu_x0,
    output logic [7:0] gpu_y0,
    output logic [7:0] gpu_x1,
    output logic [7:0] gpu_y1,
    output logic       gpu_execute_request,
    input  logic       gpu_ready,
    input  logic       gpu_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] RASTER_CMD_FILL = 3'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t        state;
    logic [37:0]   mem [DEPTH];
    logic [AW-1:0] rptr, wptr, rptr_n, wptr_n, wr_addr;
    logic [AW:0]   count, count_n;
    logic          pop, push_ok, wr_en, drop;

    assign cmd_full   = count == (AW+1)'(DEPTH);
    assign sched_idle = state == IDLE && count == '0;

    always_comb begin
        pop     = state == ISSUE && gpu_ready;
        push_ok = cmd_push && (!cmd_full || pop);
        drop    = cmd_push && !push_ok;
        wr_en   = push_ok;
        wr_addr = wptr;
        rptr_n  = pop ? rptr + AW'(1) : rptr;
        wptr_n  = push_ok ? wptr + AW'(1) : wptr;
        count_n = count + (AW+1)'(push_ok) - (AW+1)'(pop);
`ifdef RASTER_SCHED_COALESCE_FILL_EN
        // The head stays queued when it is (or is about to become) the presented
        // command and is not popped this cycle; the FILL then sits right behind it.
        if (cmd_push && cmd_op == RASTER_CMD_FILL) begin
            drop  = 1'b0;
            wr_en = 1'b1;
            if ((state == ISSUE && !gpu_ready) || (state == IDLE && count != '0)) begin
                wr_addr = rptr + AW'(1);
                wptr_n  = rptr + AW'(2);
                count_n = (AW+1)'(2);
            end else begin
                wr_addr = rptr_n;
                wptr_n  = rptr_n + AW'(1);
                count_n = (AW+1)'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= {cmd_op, cmd_colour, cmd_x0, cmd_y0, cmd_x1, cmd_y1};

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state               <= IDLE;
            rptr                <= '0;
            wptr                <= '0;
            count               <= '0;
            cmd_overflow        <= 1'b0;
            gpu_execute_request <= 1'b0;
            {gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1} <= '0;
        end else begin
            rptr         <= rptr_n;
            wptr         <= wptr_n;
            count        <= count_n;
            cmd_overflow <= cmd_overflow | drop;
            case (state)
                IDLE:
                    if (count != '0) begin
                        state               <= ISSUE;
                        gpu_execute_request <= 1'b1;
                        {gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1} <= mem[rptr];
                    end
                ISSUE:
                    if (gpu_ready) begin
                        state               <= WAIT_DONE;
                        gpu_execute_request <= 1'b0;
                    end
                WAIT_DONE:
                    if (gpu_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_raster_cmd_sched.sv
// tb_raster_cmd_sched: directed self-checking bench for raster_cmd_sched.
module tb_raster_cmd_sched;
    localparam logic [2:0] LINE = 3'd1, RECT = 3'd2, FILL = 3'd3;

    logic       clk = 0, rst_sync = 1, cmd_push = 0, gpu_ready = 0, gpu_done = 0;
    logic [2:0] cmd_op = 0, cmd_colour = 0;
    logic [7:0] cmd_x0 = 0, cmd_y0 = 0, cmd_x1 = 0, cmd_y1 = 0;
    logic       cmd_full, cmd_overflow, sched_idle, gpu_execute_request;
    logic [2:0] gpu_command, gpu_colour;
    logic [7:0] gpu_x0, gpu_y0, gpu_x1, gpu_y1;
    int total = 0, bad = 0;

    raster_cmd_sched #(.DEPTH(4)) dut (
        .clk(clk), .rst_sync(rst_sync), .cmd_push(cmd_push), .cmd_op(cmd_op),
        .cmd_colour(cmd_colour), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1),
        .cmd_y1(cmd_y1), .cmd_full(cmd_full), .cmd_overflow(cmd_overflow),
        .sched_idle(sched_idle), .gpu_command(gpu_command), .gpu_colour(gpu_colour),
        .gpu_x0(gpu_x0), .gpu_y0(gpu_y0), .gpu_x1(gpu_x1), .gpu_y1(gpu_y1),
        .gpu_execute_request(gpu_execute_request), .gpu_ready(gpu_ready), .gpu_done(gpu_done)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] col, input logic [7:0] x0,
                        input logic [7:0] y0, input logic [7:0] x1, input logic [7:0] y1);
        cmd_push = 1; cmd_op = op; cmd_colour = col;
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
        tick();
        cmd_push = 0;
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 20 && !gpu_execute_request; k++) tick();
        chk(tag, 64'(gpu_execute_request), 64'(1));
    endtask

    task automatic pulse_done();
        gpu_done = 1;
        tick();
        gpu_done = 0;
    endtask

    task automatic drain_one(input string tag, input logic [2:0] op, input logic [2:0] col,
                             input logic [7:0] x0);
        wait_req({tag, "_req"});
        chk({tag, "_op"}, 64'(gpu_command), 64'(op));
        chk({tag, "_col"}, 64'(gpu_colour), 64'(col));
        chk({tag, "_x0"}, 64'(gpu_x0), 64'(x0));
        gpu_ready = 1;
        tick();
        gpu_ready = 0;
        chk({tag, "_req_low"}, 64'(gpu_execute_request), 64'(0));
        pulse_done();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 64'(gpu_execute_request), 64'(0));
        chk({tag, "_fields"}, 64'({gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1}), 64'(0));
        chk({tag, "_full"}, 64'(cmd_full), 64'(0));
        chk({tag, "_ovf"}, 64'(cmd_overflow), 64'(0));
        chk({tag, "_idle"}, 64'(sched_idle), 64'(1));
    endtask

    initial begin
        tick(); tick();
        check_reset("rst");
        rst_sync = 0;

        // single LINE: request exactly two cycles after the push cycle, one cycle wide
        gpu_ready = 1;
        push(LINE, 3'd6, 8'd10, 8'd10, 8'd100, 8'd100);
        chk("lat_c1_req", 64'(gpu_execute_request), 64'(0));
        tick();
        chk("lat_c2_req", 64'(gpu_execute_request), 64'(1));
        chk("lat_fields", 64'({gpu_command, gpu_colour, gpu_x0, gpu_y0, gpu_x1, gpu_y1}),
            64'({LINE, 3'd6, 8'd10, 8'd10, 8'd100, 8'd100}));
        tick();
        chk("lat_c3_req", 64'(gpu_execute_request), 64'(0));
        chk("lat_busy", 64'(sched_idle), 64'(0));
        gpu_ready = 0;
        pulse_done();
        chk("lat_idle", 64'(sched_idle), 64'(1));

        // overflow: 5 pushes into DEPTH 4, only the first 4 issue
        for (int i = 0; i < 5; i++) begin
            push(RECT, 3'(i), 8'(i), 8'd1, 8'd2, 8'd3);
            if (i == 3) chk("ovf_full", 64'(cmd_full), 64'(1));
            if (i == 3) chk("ovf_not_yet", 64'(cmd_overflow), 64'(0));
        end
        chk("ovf_set", 64'(cmd_overflow), 64'(1));
        for (int i = 0; i < 4; i++) drain_one("ovf_drain", RECT, 3'(i), 8'(i));
        tick();
        chk("ovf_empty_idle", 64'(sched_idle), 64'(1));
        chk("ovf_sticky", 64'(cmd_overflow), 64'(1));
        rst_sync = 1; tick(); rst_sync = 0;
        chk("ovf_cleared", 64'(cmd_overflow), 64'(0));

        // push into a full queue alongside an ISSUE pop is accepted
        for (int i = 0; i < 4; i++) push(RECT, 3'd1, 8'(20 + i), 8'd0, 8'd0, 8'd0);
        chk("pp_full", 64'(cmd_full), 64'(1));
        gpu_ready = 1;
        push(RECT, 3'd1, 8'd24, 8'd0, 8'd0, 8'd0);
        gpu_ready = 0;
        chk("pp_still_full", 64'(cmd_full), 64'(1));
        chk("pp_no_ovf", 64'(cmd_overflow), 64'(0));
        pulse_done();
        for (int i = 1; i < 5; i++) drain_one("pp_drain", RECT, 3'd1, 8'(20 + i));
        tick();
        chk("pp_idle", 64'(sched_idle), 64'(1));

        // stray gpu_done in IDLE and ISSUE; real done -> next request two cycles later
        pulse_done();
        chk("stray_idle_req", 64'(gpu_execute_request), 64'(0));
        chk("stray_idle_idle", 64'(sched_idle), 64'(1));
        push(LINE, 3'd2, 8'd40, 8'd0, 8'd0, 8'd0);
        push(LINE, 3'd2, 8'd41, 8'd0, 8'd0, 8'd0);
        wait_req("stray_wait");
        pulse_done();
        chk("stray_issue_req", 64'(gpu_execute_request), 64'(1));
        chk("stray_issue_x0", 64'(gpu_x0), 64'(40));
        gpu_ready = 1; tick(); gpu_ready = 0;
        pulse_done();
        chk("done_d1_req", 64'(gpu_execute_request), 64'(0));
        tick();
        chk("done_d2_req", 64'(gpu_execute_request), 64'(1));
        chk("done_d2_x0", 64'(gpu_x0), 64'(41));
        drain_one("done_tail", LINE, 3'd2, 8'd41);
        tick();
        chk("done_idle", 64'(sched_idle), 64'(1));

        // FILL coalescing behind a presented RECT
        push(RECT, 3'd4, 8'd50, 8'd0, 8'd0, 8'd0);
        wait_req("fill_first");
        push(RECT, 3'd4, 8'd51, 8'd0, 8'd0, 8'd0);
        push(RECT, 3'd4, 8'd52, 8'd0, 8'd0, 8'd0);
        push(FILL, 3'd5, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("fill_no_ovf", 64'(cmd_overflow), 64'(0));
`ifdef RASTER_SCHED_COALESCE_FILL_EN
        chk("fill_full", 64'(cmd_full), 64'(0));
        drain_one("fill_r1", RECT, 3'd4, 8'd50);
        drain_one("fill_f", FILL, 3'd5, 8'd0);
`else
        chk("fill_full", 64'(cmd_full), 64'(1));
        drain_one("fill_r1", RECT, 3'd4, 8'd50);
        drain_one("fill_r2", RECT, 3'd4, 8'd51);
        drain_one("fill_r3", RECT, 3'd4, 8'd52);
        drain_one("fill_f", FILL, 3'd5, 8'd0);
`endif
        tick();
        chk("fill_idle", 64'(sched_idle), 64'(1));

        // reset during WAIT_DONE with two queued abandons everything
        for (int i = 0; i < 3; i++) push(LINE, 3'd7, 8'(60 + i), 8'd9, 8'd9, 8'd9);
        wait_req("mid_wait");
        gpu_ready = 1; tick(); gpu_ready = 0;
        chk("mid_in_wait", 64'(gpu_execute_request), 64'(0));
        rst_sync = 1; tick();
        check_reset("mid_rst");
        rst_sync = 0; tick();
        pulse_done();
        for (int i = 0; i < 4; i++) tick();
        chk("mid_no_req", 64'(gpu_execute_request), 64'(0));
        chk("mid_idle", 64'(sched_idle), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/raster_cmd_sched.md
RASTER_CMD_SCHED -- requirements
Module: raster_cmd_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 SHALL have port rst_sync  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port cmd_push  input  1  CPU enqueues cmd_* fields this cycle.
REQ-005 SHALL have ports cmd_op 3, cmd_colour 3, cmd_x0 8, cmd_y0 8, cmd_x1 8, cmd_y1 8  input  CPU raster command fields.
REQ-006 SHALL have port cmd_full  output  1  queue holds DEPTH entries.
REQ-007 SHALL have port cmd_overflow  output  1  sticky: a push was dropped.
REQ-008 SHALL have port sched_idle  output  1  queue empty, FSM IDLE, no command in flight.
REQ-009 SHALL have ports gpu_command 3, gpu_colour 3, gpu_x0 8, gpu_y0 8, gpu_x1 8, gpu_y1 8  output  command presented to the rasterizer.
REQ-010 SHALL have port gpu_execute_request  output  1  command valid toward rasterizer.
REQ-011 SHALL have port gpu_ready  input  1  rasterizer accepts when high with gpu_execute_request.
REQ-012 SHALL have port gpu_done  input  1  one-cycle pulse: accepted command finished.

Function
REQ-013 SHALL store commands in a FIFO of DEPTH 38-bit entries using wrap-around read/write pointers plus an occupancy count of width clog2(DEPTH)+1.
REQ-014 SHALL write a push when not full; a push while full SHALL be dropped and cmd_overflow SHALL be set from the next cycle.
REQ-015 SHALL, on push and pop in the same cycle with the queue full, accept both; count unchanged.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE.
REQ-017 IDLE -> ISSUE when count is nonzero; gpu_* fields registered from the FIFO head on that transition.
REQ-018 ISSUE: gpu_execute_request=1, fields held stable; on gpu_ready=1, pop head and go to WAIT_DONE.
REQ-019 WAIT_DONE: gpu_execute_request=0; on gpu_done=1 go to IDLE; gpu_done in any other state SHALL be ignored.
REQ-020 Latency: a push into an empty queue in IDLE at cycle N SHALL yield gpu_execute_request=1 at cycle N+2; the next command SHALL issue no earlier than 2 cycles after gpu_done.
REQ-021 At most one command SHALL be outstanding at the rasterizer.
REQ-022 cmd_full and sched_idle SHALL be combinational from registered state only.
REQ-023 A push to a full queue with an accepting ISSUE pop in the same cycle SHALL be accepted (REQ-015).

Reset
REQ-024 rst_sync high on a clock edge SHALL empty the FIFO, set FSM to IDLE, and clear cmd_overflow.
REQ-025 While rst_sync is high, outputs SHALL be gpu_execute_request=0, gpu_* fields=0, cmd_full=0, cmd_overflow=0, sched_idle=1.
REQ-026 Reset mid-operation SHALL abandon any in-flight command; a subsequent gpu_done SHALL be ignored.

Configuration
REQ-027 SHALL support macro RASTER_SCHED_COALESCE_FILL_EN.
REQ-028 With the macro defined, a push with cmd_op = RASTER_CMD_FILL SHALL discard all queued entries and leave the FILL as the sole entry; the in-flight or presented command SHALL be unaffected; the push SHALL never overflow.
REQ-029 With the macro defined, a FILL push coinciding with an ISSUE pop SHALL pop the presented head and leave only the FILL queued.
REQ-030 Without the macro, FILL SHALL be queued as any other command, and no coalescing logic SHALL be synthesized.

Verification
REQ-031 Reset, push LINE(10,10,100,100,colour 6) at cycle 0, gpu_ready=1 -> gpu_execute_request high at cycle 2 with those fields, low at cycle 3; sched_idle=1 after a gpu_done pulse.
REQ-032 gpu_ready=0, push 5 commands with DEPTH=4 -> cmd_full=1 after 4 pushes, 5th dropped, cmd_overflow=1, and only the first 4 commands issue in order.
REQ-033 Full queue and an ISSUE pop in the same cycle as a push -> push accepted, count stays 4, no overflow.
REQ-034 Stray gpu_done in IDLE/ISSUE ignored; gpu_done in WAIT_DONE -> next queued command requested exactly 2 cycles later.
REQ-035 Macro defined: queue 3 RECT commands with the first presented, then push FILL colour 5 -> issue order RECT#1, FILL; RECT#2 and RECT#3 never issued. Macro undefined: all 4 issued.
REQ-036 rst_sync asserted during WAIT_DONE with 2 queued -> all outputs at reset values next cycle; later gpu_done -> no request issued.
